// File: rtl/controlpath_seq.sv
// controlpath_seq: multi-cycle instruction sequencer with fault trapping, wait timeout, halt/resume
// and a retired-instruction counter; all outputs are Moore functions of state and IR.
module controlpath_seq #(
    parameter int IW      = 32,
    parameter int RAW     = 4,
    parameter int TIMEOUT = 15,
    parameter int CW      = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           go,
    input  logic [IW-1:0]  instruction,
    input  logic           instr_segv,
    input  logic           wait_instr,
    input  logic           data_segv,
    input  logic           wait_data,
    output logic           instr_req,
    output logic           pc_inc,
    output logic [2:0]     opcode,
    output logic [RAW-1:0] a_select,
    output logic [RAW-1:0] b_select,
    output logic [RAW-1:0] dst_select,
    output logic           ld,
    output logic           st,
    output logic           reg_write,
    output logic           busy,
    output logic           fault,
    output logic [2:0]     fault_code,
    output logic [CW-1:0]  retired
);
    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_RESUME, S_FAULT
    } state_t;

    localparam logic [2:0] OP_ALU  = 3'b001;
    localparam logic [2:0] OP_LD   = 3'b010;
    localparam logic [2:0] OP_ST   = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b100;

    state_t           r_state, w_next;
    logic [2:0]       r_op;
    logic [3*RAW-1:0] r_sel;
    logic [WCW-1:0]   r_wcnt;
    logic [2:0]       r_fcode, w_cause;
    logic [CW-1:0]    r_retired;
    logic             w_wait, w_tmo, w_waitst;

    assign w_waitst = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_wait   = (r_state == S_FETCH) ? wait_instr : wait_data;
    assign w_tmo    = (TIMEOUT > 0) && w_wait && (r_wcnt == WCW'(TIMEOUT));

    always_comb begin
        w_next  = r_state;
        w_cause = 3'd0;
        case (r_state)
            S_IDLE:   w_next = go ? S_FETCH : S_IDLE;
            S_FETCH: begin
                if (instr_segv) begin
                    w_next  = S_FAULT;
                    w_cause = 3'd1;
                end else if (w_tmo) begin
                    w_next  = S_FAULT;
                    w_cause = 3'd4;
                end else if (!wait_instr) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (r_op[2] && r_op != OP_HALT) begin
                    w_next  = S_FAULT;
                    w_cause = 3'd3;
                end else begin
                    w_next = (r_op == OP_HALT) ? S_HALT : S_EXEC;
                end
            end
            S_EXEC:   w_next = r_op[1] ? S_MEM : S_WB;
            S_MEM: begin
                if (data_segv) begin
                    w_next  = S_FAULT;
                    w_cause = 3'd2;
                end else if (w_tmo) begin
                    w_next  = S_FAULT;
                    w_cause = 3'd4;
                end else if (!wait_data) begin
                    w_next = S_WB;
                end
            end
            S_WB:     w_next = S_FETCH;
            // Resume spends one cycle advancing the PC past the HALT word before refetching.
            S_HALT:   w_next = go ? S_RESUME : S_HALT;
            S_RESUME: w_next = S_FETCH;
            S_FAULT:  w_next = S_FAULT;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_sel     <= '0;
            r_wcnt    <= '0;
            r_fcode   <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && w_next == S_DECODE) begin
                r_op  <= instruction[IW-1 -: 3];
                r_sel <= instruction[3*RAW-1:0];
            end
            r_wcnt <= (w_waitst && w_wait && TIMEOUT > 0) ? r_wcnt + 1'b1 : '0;
            if (w_cause != 3'd0) r_fcode <= w_cause;
            if (r_state == S_WB) r_retired <= r_retired + 1'b1;
        end
    end

    assign instr_req  = (r_state == S_FETCH);
    assign pc_inc     = (r_state == S_WB) || (r_state == S_RESUME);
    assign opcode     = r_op;
    assign a_select   = r_sel[2*RAW-1:RAW];
    assign b_select   = r_sel[3*RAW-1:2*RAW];
    assign dst_select = r_sel[RAW-1:0];
    assign ld         = (r_state == S_MEM) && (r_op == OP_LD);
    assign st         = (r_state == S_MEM) && (r_op == OP_ST);
    assign reg_write  = (r_state == S_WB) && (r_op == OP_ALU || r_op == OP_LD);
    assign busy       = !(r_state == S_IDLE || r_state == S_HALT || r_state == S_FAULT);
    assign fault      = (r_state == S_FAULT);
    assign fault_code = r_fcode;
    assign retired    = r_retired;
endmodule

// File: tb/tb_controlpath_seq.sv
// tb_controlpath_seq: directed scenario tests for controlpath_seq, plus a CW=2 instance for wrap.
module tb_controlpath_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        go = 1'b0;
    logic [31:0] instruction = '0;
    logic        instr_segv = 1'b0, wait_instr = 1'b0, data_segv = 1'b0, wait_data = 1'b0;
    logic        instr_req, pc_inc, ld, st, reg_write, busy, fault;
    logic [2:0]  opcode, fault_code;
    logic [3:0]  a_select, b_select, dst_select;
    logic [15:0] retired;
    logic        w_instr_req, w_pc_inc, w_ld, w_st, w_reg_write, w_busy, w_fault;
    logic [2:0]  w_opcode, w_fault_code;
    logic [3:0]  w_a, w_b, w_d;
    logic [1:0]  w_retired;
    int checks = 0, errors = 0;

    localparam logic [31:0] ALU_W = 32'h2000_0321, LD_W = 32'h4000_0456, ST_W = 32'h6000_0456;
    localparam logic [31:0] HALT_W = 32'h8000_0000, NOP_W = 32'h0, ILL_W = 32'hC000_0000;

    controlpath_seq #(.IW(32), .RAW(4), .TIMEOUT(15), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .instruction(instruction),
        .instr_segv(instr_segv), .wait_instr(wait_instr), .data_segv(data_segv), .wait_data(wait_data),
        .instr_req(instr_req), .pc_inc(pc_inc), .opcode(opcode), .a_select(a_select),
        .b_select(b_select), .dst_select(dst_select), .ld(ld), .st(st), .reg_write(reg_write),
        .busy(busy), .fault(fault), .fault_code(fault_code), .retired(retired)
    );

    controlpath_seq #(.IW(32), .RAW(4), .TIMEOUT(15), .CW(2)) u_w (
        .clk(clk), .rst_n(rst_n), .go(go), .instruction(instruction),
        .instr_segv(instr_segv), .wait_instr(wait_instr), .data_segv(data_segv), .wait_data(wait_data),
        .instr_req(w_instr_req), .pc_inc(w_pc_inc), .opcode(w_opcode), .a_select(w_a),
        .b_select(w_b), .dst_select(w_d), .ld(w_ld), .st(w_st), .reg_write(w_reg_write),
        .busy(w_busy), .fault(w_fault), .fault_code(w_fault_code), .retired(w_retired)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        go = 1'b0; instr_segv = 1'b0; wait_instr = 1'b0; data_segv = 1'b0; wait_data = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic start(input logic [31:0] word);
        instruction = word;
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({instr_req, pc_inc, ld, st, reg_write, busy, fault} !== 7'd0) begin
            errors++; $display("FAIL reset_strobes got %b want 0000000", {instr_req, pc_inc, ld, st, reg_write, busy, fault});
        end
        checks++;
        if ({opcode, a_select, b_select, dst_select, fault_code, retired} !== '0) begin
            errors++; $display("FAIL reset_fields got op=%0d a=%0d b=%0d d=%0d fc=%0d ret=%0d want all 0", opcode, a_select, b_select, dst_select, fault_code, retired);
        end
        tick();
        rst_n = 1'b1;
        tick();
        start(NOP_W);
        checks++;
        if (instr_req !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL go_to_fetch got instr_req=%b busy=%b want 1 1", instr_req, busy);
        end
    endtask

    task automatic test_alu();
        do_reset();
        start(ALU_W);
        tick();
        checks++;
        if (instr_req !== 1'b0 || opcode !== 3'd1 || a_select !== 4'd2 || b_select !== 4'd3 || dst_select !== 4'd1) begin
            errors++; $display("FAIL alu_decode got req=%b op=%0d a=%0d b=%0d d=%0d want 0 1 2 3 1", instr_req, opcode, a_select, b_select, dst_select);
        end
        tick();
        checks++;
        if (pc_inc !== 1'b0 || reg_write !== 1'b0) begin
            errors++; $display("FAIL alu_exec got pc_inc=%b reg_write=%b want 0 0", pc_inc, reg_write);
        end
        tick();
        checks++;
        if (pc_inc !== 1'b1 || reg_write !== 1'b1) begin
            errors++; $display("FAIL alu_wb got pc_inc=%b reg_write=%b want 1 1", pc_inc, reg_write);
        end
        tick();
        checks++;
        if (retired !== 16'd1 || pc_inc !== 1'b0 || instr_req !== 1'b1) begin
            errors++; $display("FAIL alu_retire got retired=%0d pc_inc=%b req=%b want 1 0 1", retired, pc_inc, instr_req);
        end
    endtask

    task automatic test_mem(input logic is_st);
        int nstb, nother, wbc;
        logic rw;
        nstb = 0; nother = 0; wbc = 0; rw = 1'bx;
        do_reset();
        wait_data = 1'b1;
        start(is_st ? ST_W : LD_W);
        for (int c = 2; c <= 9; c++) begin
            tick();
            wait_data = (c <= 6);
            if (is_st ? st : ld) nstb++;
            if (is_st ? ld : st) nother++;
            if (pc_inc) begin
                wbc = c;
                rw = reg_write;
            end
        end
        checks++;
        if (nstb != 4 || nother != 0) begin
            errors++; $display("FAIL mem_strobe st=%b got %0d/%0d cycles want 4/0", is_st, nstb, nother);
        end
        checks++;
        if (wbc != 8 || rw !== !is_st) begin
            errors++; $display("FAIL mem_wb st=%b got cycle %0d reg_write=%b want 8 %b", is_st, wbc, rw, !is_st);
        end
        checks++;
        if (retired !== 16'd1) begin
            errors++; $display("FAIL mem_retired st=%b got %0d want 1", is_st, retired);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        wait_instr = 1'b1;
        start(ALU_W);
        repeat (15) tick();
        checks++;
        if (instr_req !== 1'b1 || fault !== 1'b0) begin
            errors++; $display("FAIL timeout_early got req=%b fault=%b want 1 0", instr_req, fault);
        end
        tick();
        checks++;
        if (fault !== 1'b1 || fault_code !== 3'd4 || busy !== 1'b0 || instr_req !== 1'b0) begin
            errors++; $display("FAIL timeout_fault got fault=%b code=%0d busy=%b req=%b want 1 4 0 0", fault, fault_code, busy, instr_req);
        end
        wait_instr = 1'b0;
        go = 1'b1;
        repeat (3) tick();
        go = 1'b0;
        checks++;
        if (fault !== 1'b1 || fault_code !== 3'd4 || instr_req !== 1'b0 || pc_inc !== 1'b0) begin
            errors++; $display("FAIL timeout_sticky got fault=%b code=%0d req=%b pc_inc=%b want 1 4 0 0", fault, fault_code, instr_req, pc_inc);
        end
    endtask

    task automatic test_segv();
        do_reset();
        wait_instr = 1'b1;
        instr_segv = 1'b1;
        start(ALU_W);
        tick();
        checks++;
        if (fault !== 1'b1 || fault_code !== 3'd1) begin
            errors++; $display("FAIL instr_segv got fault=%b code=%0d want 1 1", fault, fault_code);
        end
        do_reset();
        start(LD_W);
        repeat (3) tick();
        data_segv = 1'b1;
        wait_data = 1'b1;
        checks++;
        if (ld !== 1'b1) begin
            errors++; $display("FAIL data_segv_mem got ld=%b want 1", ld);
        end
        tick();
        checks++;
        if (fault !== 1'b1 || fault_code !== 3'd2 || retired !== 16'd0 || ld !== 1'b0) begin
            errors++; $display("FAIL data_segv got fault=%b code=%0d retired=%0d ld=%b want 1 2 0 0", fault, fault_code, retired, ld);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        start(ILL_W);
        tick();
        checks++;
        if (opcode !== 3'd6 || pc_inc !== 1'b0 || fault !== 1'b0) begin
            errors++; $display("FAIL illegal_decode got op=%0d pc_inc=%b fault=%b want 6 0 0", opcode, pc_inc, fault);
        end
        tick();
        checks++;
        if (fault !== 1'b1 || fault_code !== 3'd3 || pc_inc !== 1'b0) begin
            errors++; $display("FAIL illegal_fault got fault=%b code=%0d pc_inc=%b want 1 3 0", fault, fault_code, pc_inc);
        end
    endtask

    task automatic test_halt();
        int npc;
        npc = 0;
        do_reset();
        start(HALT_W);
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0 || fault !== 1'b0 || pc_inc !== 1'b0) begin
            errors++; $display("FAIL halt_enter got busy=%b fault=%b pc_inc=%b want 0 0 0", busy, fault, pc_inc);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (pc_inc || busy) npc++;
        end
        checks++;
        if (npc != 0) begin
            errors++; $display("FAIL halt_hold got %0d active cycles want 0", npc);
        end
        go = 1'b1;
        tick();
        go = 1'b0;
        instruction = NOP_W;
        checks++;
        if (pc_inc !== 1'b1 || instr_req !== 1'b0) begin
            errors++; $display("FAIL halt_exit got pc_inc=%b req=%b want 1 0", pc_inc, instr_req);
        end
        tick();
        checks++;
        if (instr_req !== 1'b1 || pc_inc !== 1'b0 || retired !== 16'd0) begin
            errors++; $display("FAIL halt_refetch got req=%b pc_inc=%b retired=%0d want 1 0 0", instr_req, pc_inc, retired);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        start(NOP_W);
        repeat (12) tick();
        checks++;
        if (w_retired !== 2'd3 || retired !== 16'd3) begin
            errors++; $display("FAIL wrap_three got cw2=%0d cw16=%0d want 3 3", w_retired, retired);
        end
        repeat (4) tick();
        checks++;
        if (w_retired !== 2'd0 || retired !== 16'd4 || w_instr_req !== 1'b1) begin
            errors++; $display("FAIL wrap_zero got cw2=%0d cw16=%0d req=%b want 0 4 1", w_retired, retired, w_instr_req);
        end
    endtask

    task automatic test_back_to_back();
        int npc;
        logic prev;
        npc = 0; prev = 1'b0;
        do_reset();
        start(ALU_W);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (pc_inc && prev) npc++;
            prev = pc_inc;
        end
        checks++;
        if (npc != 0 || retired !== 16'd3) begin
            errors++; $display("FAIL back_to_back got double_pc=%0d retired=%0d want 0 3", npc, retired);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        start(ALU_W);
        repeat (2) tick();
        checks++;
        if (busy !== 1'b1 || opcode !== 3'd1) begin
            errors++; $display("FAIL mid_exec got busy=%b op=%0d want 1 1", busy, opcode);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({instr_req, pc_inc, ld, st, reg_write, busy, fault} !== 7'd0 || {opcode, a_select, b_select, dst_select, retired} !== '0) begin
            errors++; $display("FAIL mid_reset got strobes=%b op=%0d a=%0d ret=%0d want 0", {instr_req, pc_inc, ld, st, reg_write, busy, fault}, opcode, a_select, retired);
        end
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0 || instr_req !== 1'b0 || retired !== 16'd0) begin
            errors++; $display("FAIL mid_idle got busy=%b req=%b retired=%0d want 0 0 0", busy, instr_req, retired);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem(1'b0);
        test_mem(1'b1);
        test_timeout();
        test_segv();
        test_illegal();
        test_halt();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
